// File: rtl/kbd_pkg.sv
// ============================================================================
// kbd_pkg : scancode constants, decoder states and ASCII codes for kbd_key_fifo
// Revision: 1.0
// ============================================================================
`default_nettype none

package kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kbd_state_t;

   localparam logic [7:0] ASC_UP    = 8'h11;
   localparam logic [7:0] ASC_DOWN  = 8'h12;
   localparam logic [7:0] ASC_LEFT  = 8'h13;
   localparam logic [7:0] ASC_RIGHT = 8'h14;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_BS    = 8'h08;
   localparam logic [7:0] ASC_ESC   = 8'h1B;
   localparam logic [7:0] ASC_SPACE = 8'h20;

   function automatic logic is_modifier(input logic [7:0] sc);
      return (sc == SC_LSHIFT) || (sc == SC_RSHIFT) || (sc == SC_CAPS);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_ascii_rom.sv
// ============================================================================
// ps2_ascii_rom : combinational PS/2 set-2 make code to ASCII translation
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_ascii_rom
   import kbd_pkg::*;
(
   input  logic [7:0] scancode,
   input  logic       extended,
   input  logic       shifted,
   input  logic       caps,
   output logic       mapped,
   output logic [7:0] ascii
);

   logic [7:0] lo;
   logic [7:0] hi;
   logic       letter;

   always_comb begin
      lo = 8'h00;
      hi = 8'h00;
      if (extended) begin
         case (scancode)
            8'h75:   lo = ASC_UP;
            8'h72:   lo = ASC_DOWN;
            8'h6B:   lo = ASC_LEFT;
            8'h74:   lo = ASC_RIGHT;
            default: lo = 8'h00;
         endcase
         hi = lo;
      end else begin
         case (scancode)
            8'h1C: lo = "a";   8'h32: lo = "b";   8'h21: lo = "c";
            8'h23: lo = "d";   8'h24: lo = "e";   8'h2B: lo = "f";
            8'h34: lo = "g";   8'h33: lo = "h";   8'h43: lo = "i";
            8'h3B: lo = "j";   8'h42: lo = "k";   8'h4B: lo = "l";
            8'h3A: lo = "m";   8'h31: lo = "n";   8'h44: lo = "o";
            8'h4D: lo = "p";   8'h15: lo = "q";   8'h2D: lo = "r";
            8'h1B: lo = "s";   8'h2C: lo = "t";   8'h3C: lo = "u";
            8'h2A: lo = "v";   8'h1D: lo = "w";   8'h22: lo = "x";
            8'h35: lo = "y";   8'h1A: lo = "z";
            8'h16: begin lo = "1";  hi = "!";  end
            8'h1E: begin lo = "2";  hi = "@";  end
            8'h26: begin lo = "3";  hi = "#";  end
            8'h25: begin lo = "4";  hi = "$";  end
            8'h2E: begin lo = "5";  hi = "%";  end
            8'h36: begin lo = "6";  hi = "^";  end
            8'h3D: begin lo = "7";  hi = "&";  end
            8'h3E: begin lo = "8";  hi = "*";  end
            8'h46: begin lo = "9";  hi = "(";  end
            8'h45: begin lo = "0";  hi = ")";  end
            8'h0E: begin lo = 8'h60; hi = "~";  end
            8'h4E: begin lo = "-";  hi = "_";  end
            8'h55: begin lo = "=";  hi = "+";  end
            8'h54: begin lo = "[";  hi = "{";  end
            8'h5B: begin lo = "]";  hi = "}";  end
            8'h5D: begin lo = "\\"; hi = "|";  end
            8'h4C: begin lo = ";";  hi = ":";  end
            8'h52: begin lo = "'";  hi = "\""; end
            8'h41: begin lo = ",";  hi = "<";  end
            8'h49: begin lo = ".";  hi = ">";  end
            8'h4A: begin lo = "/";  hi = "?";  end
            8'h29: begin lo = ASC_SPACE; hi = ASC_SPACE; end
            8'h5A: begin lo = ASC_CR;    hi = ASC_CR;    end
            8'h66: begin lo = ASC_BS;    hi = ASC_BS;    end
            8'h76: begin lo = ASC_ESC;   hi = ASC_ESC;   end
            default: ;
         endcase
      end
      // Letters carry only the lowercase code; caps only affects letters.
      letter = (lo >= "a") && (lo <= "z");
      if (letter)
         hi = lo - 8'h20;
      mapped = (lo != 8'h00);
      if (letter)
         ascii = (shifted ^ caps) ? hi : lo;
      else
         ascii = shifted ? hi : lo;
   end

endmodule

`default_nettype wire

// File: rtl/kbd_key_fifo.sv
// ============================================================================
// kbd_key_fifo : PS/2 set-2 decoder with shift/caps handling and ASCII key FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module kbd_key_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                     CLK_CPU,
   input  logic                     resetn,
   input  logic [7:0]               scancode_in,
   input  logic                     scancode_valid,
   input  logic                     key_pop,
   input  logic                     clean_key_buffer,
   output logic [7:0]               pressed_key,
   output logic                     keyboard_valid,
   output logic [$clog2(DEPTH):0]   key_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   kbd_state_t     state;
   logic           shift;
   logic           caps;
   logic [7:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   logic           rom_mapped;
   logic [7:0]     rom_ascii;
   logic           make_ctx;
   logic           push_req;
   logic           full;
   logic           do_pop;
   logic           do_push;

   ps2_ascii_rom u_rom (
      .scancode (scancode_in),
      .extended (state == ST_EXT),
      .shifted  (shift),
      .caps     (caps),
      .mapped   (rom_mapped),
      .ascii    (rom_ascii)
   );

   always_comb begin
      make_ctx = 1'b0;
      if (scancode_valid) begin
         case (state)
            ST_IDLE: make_ctx = (scancode_in != SC_BREAK) && (scancode_in != SC_EXT);
            ST_EXT:  make_ctx = (scancode_in != SC_BREAK);
            default: make_ctx = 1'b0;
         endcase
      end
      push_req = make_ctx && rom_mapped &&
                 !((state == ST_IDLE) && is_modifier(scancode_in));
      full     = (key_count == FULL_COUNT);
      do_pop   = key_pop && keyboard_valid;
      // A pop frees the slot the push lands in, so full does not block it.
      do_push  = push_req && (!full || do_pop);
   end

   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         shift <= 1'b0;
         caps  <= 1'b0;
      end else if (scancode_valid) begin
         case (state)
            ST_IDLE: begin
               if (scancode_in == SC_BREAK)
                  state <= ST_BRK;
               else if (scancode_in == SC_EXT)
                  state <= ST_EXT;
               else begin
                  if (scancode_in == SC_LSHIFT || scancode_in == SC_RSHIFT)
                     shift <= 1'b1;
                  if (scancode_in == SC_CAPS)
                     caps <= ~caps;
               end
            end
            ST_BRK: begin
               if (scancode_in == SC_LSHIFT || scancode_in == SC_RSHIFT)
                  shift <= 1'b0;
               state <= ST_IDLE;
            end
            ST_EXT:     state <= (scancode_in == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
            ST_EXT_BRK: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         key_count      <= '0;
         overflow       <= 1'b0;
         keyboard_valid <= 1'b0;
      end else if (clean_key_buffer) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         key_count      <= '0;
         overflow       <= 1'b0;
         keyboard_valid <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10: begin
               key_count      <= key_count + CW'(1);
               keyboard_valid <= 1'b1;
            end
            2'b01: begin
               key_count      <= key_count - CW'(1);
               keyboard_valid <= (key_count != CW'(1));
            end
            default: ;
         endcase
         if (push_req && full && !do_pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge CLK_CPU) begin
      if (do_push && !clean_key_buffer)
         mem[wr_ptr] <= rom_ascii;
   end

   assign pressed_key = keyboard_valid ? mem[rd_ptr] : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_kbd_key_fifo.sv
// ============================================================================
// tb_kbd_key_fifo : directed self-checking bench for kbd_key_fifo
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_kbd_key_fifo;

   localparam int DEPTH = 8;

   logic         CLK_CPU;
   logic         resetn;
   logic [7:0]   scancode_in;
   logic         scancode_valid;
   logic         key_pop;
   logic         clean_key_buffer;
   logic [7:0]   pressed_key;
   logic         keyboard_valid;
   logic [3:0]   key_count;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   kbd_key_fifo #(.DEPTH(DEPTH)) dut (
      .CLK_CPU          (CLK_CPU),
      .resetn           (resetn),
      .scancode_in      (scancode_in),
      .scancode_valid   (scancode_valid),
      .key_pop          (key_pop),
      .clean_key_buffer (clean_key_buffer),
      .pressed_key      (pressed_key),
      .keyboard_valid   (keyboard_valid),
      .key_count        (key_count),
      .overflow         (overflow)
   );

   initial CLK_CPU = 1'b0;
   always #5 CLK_CPU = ~CLK_CPU;

   // Inputs change on the falling edge; outputs are sampled on the falling edge.
   task automatic send(input logic [7:0] b);
      @(negedge CLK_CPU);
      scancode_in    = b;
      scancode_valid = 1'b1;
      @(negedge CLK_CPU);
      scancode_valid = 1'b0;
   endtask

   task automatic pop();
      @(negedge CLK_CPU);
      key_pop = 1'b1;
      @(negedge CLK_CPU);
      key_pop = 1'b0;
   endtask

   task automatic clean();
      @(negedge CLK_CPU);
      clean_key_buffer = 1'b1;
      @(negedge CLK_CPU);
      clean_key_buffer = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #12;
      checks++; if (pressed_key !== 8'h00) begin errors++; $display("FAIL reset_key: got %h expected 00", pressed_key); end
      checks++; if (keyboard_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", keyboard_valid); end
      checks++; if (key_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", key_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      @(negedge CLK_CPU);
      resetn = 1'b1;
   endtask

   task automatic test_make_pop();
      send(8'h1C);
      checks++; if (pressed_key !== 8'h61) begin errors++; $display("FAIL make_key: got %h expected 61", pressed_key); end
      checks++; if (keyboard_valid !== 1'b1) begin errors++; $display("FAIL make_valid: got %b expected 1", keyboard_valid); end
      checks++; if (key_count !== 4'd1) begin errors++; $display("FAIL make_count: got %0d expected 1", key_count); end
      pop();
      checks++; if (keyboard_valid !== 1'b0) begin errors++; $display("FAIL pop_valid: got %b expected 0", keyboard_valid); end
      checks++; if (pressed_key !== 8'h00) begin errors++; $display("FAIL pop_key: got %h expected 00", pressed_key); end
   endtask

   task automatic test_shift();
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12); send(8'h1C);
      checks++; if (key_count !== 4'd2) begin errors++; $display("FAIL shift_count: got %0d expected 2", key_count); end
      checks++; if (pressed_key !== 8'h41) begin errors++; $display("FAIL shift_upper: got %h expected 41", pressed_key); end
      pop();
      checks++; if (pressed_key !== 8'h61) begin errors++; $display("FAIL shift_lower: got %h expected 61", pressed_key); end
      pop();
      // Right shift with a digit and punctuation
      send(8'h59); send(8'h16); send(8'h4A); send(8'hF0); send(8'h59); send(8'h4A);
      checks++; if (pressed_key !== 8'h21) begin errors++; $display("FAIL rshift_digit: got %h expected 21", pressed_key); end
      pop();
      checks++; if (pressed_key !== 8'h3F) begin errors++; $display("FAIL rshift_punct: got %h expected 3f", pressed_key); end
      pop();
      checks++; if (pressed_key !== 8'h2F) begin errors++; $display("FAIL unshift_punct: got %h expected 2f", pressed_key); end
      pop();
   endtask

   task automatic test_caps();
      send(8'h58); send(8'h16); send(8'h1C);
      checks++; if (key_count !== 4'd2) begin errors++; $display("FAIL caps_count: got %0d expected 2", key_count); end
      checks++; if (pressed_key !== 8'h31) begin errors++; $display("FAIL caps_digit: got %h expected 31", pressed_key); end
      pop();
      checks++; if (pressed_key !== 8'h41) begin errors++; $display("FAIL caps_letter: got %h expected 41", pressed_key); end
      pop();
      // Shift while caps is on lowers letters again
      send(8'h12); send(8'h1C);
      checks++; if (pressed_key !== 8'h61) begin errors++; $display("FAIL caps_shift_letter: got %h expected 61", pressed_key); end
      pop();
      send(8'hF0); send(8'h12); send(8'h58); send(8'h29); send(8'h1C);
      checks++; if (pressed_key !== 8'h20) begin errors++; $display("FAIL space: got %h expected 20", pressed_key); end
      pop();
      checks++; if (pressed_key !== 8'h61) begin errors++; $display("FAIL caps_off_letter: got %h expected 61", pressed_key); end
      pop();
   endtask

   task automatic test_ext();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      checks++; if (key_count !== 4'd1) begin errors++; $display("FAIL ext_count: got %0d expected 1", key_count); end
      checks++; if (pressed_key !== 8'h11) begin errors++; $display("FAIL ext_up: got %h expected 11", pressed_key); end
      pop();
      // Plain 0x75 is unmapped; extended 0x6B is left arrow
      send(8'h75); send(8'hE0); send(8'h6B);
      checks++; if (key_count !== 4'd1) begin errors++; $display("FAIL ext_unmapped_count: got %0d expected 1", key_count); end
      checks++; if (pressed_key !== 8'h13) begin errors++; $display("FAIL ext_left: got %h expected 13", pressed_key); end
      pop();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH + 1; i++) send(8'h1C);
      checks++; if (key_count !== 4'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", key_count, DEPTH); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      clean();
      checks++; if (key_count !== 4'd0) begin errors++; $display("FAIL clean_count: got %0d expected 0", key_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clean_flag: got %b expected 0", overflow); end
      for (int i = 0; i < DEPTH; i++) send(8'h1C);
      @(negedge CLK_CPU);
      scancode_in = 8'h32; scancode_valid = 1'b1; key_pop = 1'b1;
      @(negedge CLK_CPU);
      scancode_valid = 1'b0; key_pop = 1'b0;
      checks++; if (key_count !== 4'(DEPTH)) begin errors++; $display("FAIL full_pushpop_count: got %0d expected %0d", key_count, DEPTH); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_flag: got %b expected 0", overflow); end
      for (int i = 0; i < DEPTH - 1; i++) pop();
      checks++; if (pressed_key !== 8'h62) begin errors++; $display("FAIL wrap_tail: got %h expected 62", pressed_key); end
      pop();
      pop();
      checks++; if (key_count !== 4'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", key_count); end
      checks++; if (keyboard_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid: got %b expected 0", keyboard_valid); end
      // Flush wins over a simultaneous push; shift survives a flush
      send(8'h1C);
      @(negedge CLK_CPU);
      scancode_in = 8'h12; scancode_valid = 1'b1; clean_key_buffer = 1'b1;
      @(negedge CLK_CPU);
      scancode_valid = 1'b0; clean_key_buffer = 1'b0;
      checks++; if (key_count !== 4'd0) begin errors++; $display("FAIL clean_push_count: got %0d expected 0", key_count); end
      send(8'h1C);
      checks++; if (pressed_key !== 8'h41) begin errors++; $display("FAIL clean_keeps_shift: got %h expected 41", pressed_key); end
      send(8'hF0); send(8'h12);
      pop();
   endtask

   task automatic test_reset_mid_prefix();
      send(8'hF0);
      @(negedge CLK_CPU);
      resetn = 1'b0;
      @(negedge CLK_CPU);
      resetn = 1'b1;
      send(8'h1C);
      checks++; if (key_count !== 4'd1) begin errors++; $display("FAIL midreset_count: got %0d expected 1", key_count); end
      checks++; if (pressed_key !== 8'h61) begin errors++; $display("FAIL midreset_key: got %h expected 61", pressed_key); end
   endtask

   initial begin
      scancode_in      = 8'h00;
      scancode_valid   = 1'b0;
      key_pop          = 1'b0;
      clean_key_buffer = 1'b0;
      test_reset();
      test_make_pop();
      test_shift();
      test_caps();
      test_ext();
      test_overflow();
      test_reset_mid_prefix();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/kbd_key_fifo.md
# kbd_key_fifo

Decodes raw PS/2 set-2 scancode bytes from the keyboard receiver into ASCII key codes and buffers them for the memory-mapped keyboard register. It sits between `keyboard` (raw bytes) and `memory` (consumer of `pressed_key`/`keyboard_valid`). It handles break (0xF0) and extended (0xE0) prefixes, Shift and Caps Lock state, and FIFO flush and overflow.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CLK_CPU`  in  1  CPU clock; all state on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `scancode_in`  in  8  raw scancode byte from the keyboard receiver.
- `scancode_valid`  in  1  single-cycle strobe; `scancode_in` is valid this cycle.
- `key_pop`  in  1  memory consumed the head entry.
- `clean_key_buffer`  in  1  flush the FIFO and clear `overflow`.
- `pressed_key`  out  8  ASCII code at the FIFO head; 0x00 when empty.
- `keyboard_valid`  out  1  FIFO non-empty.
- `key_count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `overflow`  out  1  sticky flag: a key was dropped because the FIFO was full.

## Operation
- Reset: all outputs 0, FSM in IDLE, shift=0, caps=0, FIFO pointers 0.
- Decoder FSM states: IDLE, BRK, EXT, EXT_BRK. Transitions happen only on `scancode_valid`.
  - IDLE: 0xF0→BRK; 0xE0→EXT; any other byte is a make code, processed, stay in IDLE.
  - BRK: byte is a break code, processed, →IDLE.
  - EXT: 0xF0→EXT_BRK; any other byte is an extended make, processed, →IDLE.
  - EXT_BRK: byte consumed with no effect, →IDLE.
- Modifiers:
  - Make 0x12 or 0x59 sets shift; break of either clears shift.
  - Make 0x58 toggles caps.
  - Modifier codes push nothing.
- Translation is done by `ps2_ascii_rom`.
  - Letters (e.g. 0x1C 'a'): lowercase, uppercase when shift XOR caps.
  - Digits and punctuation: shifted variant when shift=1.
  - 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x76→0x1B.
  - Extended makes: 0x75→0x11, 0x72→0x12, 0x6B→0x13, 0x74→0x14.
  - Unmapped codes and other breaks push nothing.
- Typematic repeats (repeated make codes) each push a new entry.
- FIFO:
  - Push when a mapped make decodes and the FIFO is not full.
  - Pop on `key_pop` when `keyboard_valid`; `key_pop` while empty is ignored.
  - Push and pop in the same cycle: both happen, count unchanged, legal even when full.
  - Push when full without a pop: entry dropped, `overflow`←1.
  - Pointers wrap modulo DEPTH.
- `clean_key_buffer`:
  - Empties the FIFO and clears `overflow`. A push or pop in the same cycle is discarded.
  - Does not alter FSM, shift or caps state.

## Timing
- Latency: a scancode strobed in cycle N gives `keyboard_valid`=1 and the new `pressed_key` in cycle N+1.
- `pressed_key` is driven combinationally from the head register. After a pop, the next entry, or 0x00 if empty, appears the following cycle.
- `key_count` and `overflow` are registered and update on the same edge as the push or pop.
- Asynchronous reset mid-prefix (e.g. after 0xF0) returns the FSM to IDLE immediately. The next byte is treated as a make code.

## Structure
- `kbd_pkg`:
  - Scancode constants: `SC_BREAK`=0xF0, `SC_EXT`=0xE0, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CAPS`.
  - Decoder state enum `kbd_state_t`.
  - ASCII control constants (arrows, CR, BS, ESC).
- Sub-module `ps2_ascii_rom`:
  - Combinational: (scancode, extended, shifted, caps) → {mapped, ascii}.
  - Instantiated once. The FIFO and FSM live in the top block.

## Test plan
- Make 0x1C → after one cycle `pressed_key`=0x61, `keyboard_valid`=1, `key_count`=1. Then `key_pop` → `keyboard_valid`=0, `pressed_key`=0x00.
- 0x12, 0x1C, 0xF0 0x1C, 0xF0 0x12, 0x1C → FIFO holds 0x41 then 0x61, count=2.
- 0x58 then 0x16 → 0x21? No: caps does not affect digits, so 0x31; 0x1C → 0x41.
- 0xE0 0x75, then 0xE0 0xF0 0x75 → exactly one entry, 0x11.
- DEPTH+1 makes of 0x1C with no pops → count=DEPTH, `overflow`=1. `clean_key_buffer` → count=0, `overflow`=0. Push and pop on a full FIFO → count stays DEPTH, `overflow` stays 0.
- Send 0xF0, assert `resetn`=0 for one cycle, then 0x1C → one entry 0x61.
